// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the I/D cache line-fill memory arbiter.
package mem_arbiter_pkg;

    localparam int LINE_WORDS_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_id_t;

    // Clear the byte offset within a line of lw 32-bit words.
    function automatic logic [31:0] line_base(input logic [31:0] addr, input int lw);
        return addr & ~((32'(lw) << 2) - 32'd1);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side request/response signals plus the shared memory beat bus.
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int LINE_WORDS = LINE_WORDS_DEF
);
    logic                    i_req;
    logic [31:0]             i_addr;
    logic                    i_done;
    logic                    d_req;
    logic                    d_we;
    logic [31:0]             d_addr;
    logic [32*LINE_WORDS-1:0] d_wline;
    logic                    d_done;
    logic [32*LINE_WORDS-1:0] rline;
    logic                    busy;
    logic                    mem_req;
    logic                    mem_we;
    logic [31:0]             mem_addr;
    logic [31:0]             mem_wdata;
    logic [31:0]             mem_rdata;
    logic                    mem_ack;

    modport master (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wline, mem_rdata, mem_ack,
        output i_done, d_done, rline, busy, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output i_req, i_addr, d_req, d_we, d_addr, d_wline, mem_rdata, mem_ack,
        input  i_done, d_done, rline, busy, mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_arbiter_arb_rr2.sv
// Two-requester round-robin picker: combinational pick, last winner registered on take.
module arb_rr2
    import mem_arbiter_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  logic    req_i,
    input  logic    req_d,
    input  logic    take,
    output logic    gnt_vld,
    output req_id_t gnt_id
);
    req_id_t last_grant;

    always_comb begin
        gnt_vld = req_i | req_d;
        gnt_id  = REQ_I;
        if (req_i && req_d) begin
            gnt_id = (last_grant == REQ_I) ? REQ_D : REQ_I;
        end else if (req_d) begin
            gnt_id = REQ_D;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant <= REQ_I;
        end else if (take && gnt_vld) begin
            last_grant <= gnt_id;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I-cache fills and D-cache fills/write-backs onto one memory beat bus.
// One line burst at a time; beats wait on mem_ack, done pulses one cycle after the last ack.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int LINE_WORDS = LINE_WORDS_DEF
)(
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.master bus
);
    localparam int            BW        = $clog2(LINE_WORDS);
    localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_WORDS - 1);

    state_t                       state_q, state_d;
    logic [BW-1:0]                beat_q;
    req_id_t                      owner_q;
    logic                         we_q;
    logic [31:0]                  base_q;
    logic [LINE_WORDS-1:0][31:0]  wline_q;
    logic [LINE_WORDS-1:0][31:0]  rline_q;

    logic    gnt_vld;
    req_id_t gnt_id;
    logic    grant;
    logic    last_ack;

    arb_rr2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req_i   (bus.i_req),
        .req_d   (bus.d_req),
        .take    (state_q == IDLE),
        .gnt_vld (gnt_vld),
        .gnt_id  (gnt_id)
    );

    assign grant    = (state_q == IDLE) && gnt_vld;
    assign last_ack = (state_q == BURST) && bus.mem_ack && (beat_q == LAST_BEAT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (gnt_vld) state_d = BURST;
            BURST:   if (last_ack) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Everything the burst needs is captured at grant so the caches may move on.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            beat_q  <= '0;
            owner_q <= REQ_I;
            we_q    <= 1'b0;
            base_q  <= '0;
            wline_q <= '0;
            rline_q <= '0;
        end else begin
            if (grant) begin
                owner_q <= gnt_id;
                base_q  <= line_base((gnt_id == REQ_I) ? bus.i_addr : bus.d_addr, LINE_WORDS);
                we_q    <= (gnt_id == REQ_D) && bus.d_we;
                beat_q  <= '0;
                if (gnt_id == REQ_D && bus.d_we) begin
                    wline_q <= bus.d_wline;
                end
            end
            if (state_q == BURST && bus.mem_ack) begin
                if (!we_q) begin
                    rline_q[beat_q] <= bus.mem_rdata;
                end
                if (beat_q != LAST_BEAT) begin
                    beat_q <= beat_q + 1'b1;
                end
            end
            if (state_q == DONE) begin
                beat_q <= '0;
            end
        end
    end

    assign bus.mem_req   = (state_q == BURST);
    assign bus.mem_we    = (state_q == BURST) && we_q;
    assign bus.mem_addr  = base_q + 32'({beat_q, 2'b00});
    assign bus.mem_wdata = wline_q[beat_q];
    assign bus.i_done    = (state_q == DONE) && (owner_q == REQ_I);
    assign bus.d_done    = (state_q == DONE) && (owner_q == REQ_D);
    assign bus.busy      = (state_q != IDLE);
    assign bus.rline     = rline_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int LW = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_arbiter_if #(.LINE_WORDS(LW)) ifc ();
    mem_arbiter #(.LINE_WORDS(LW)) dut (.clk(clk), .reset(reset), .bus(ifc));

    int errs   = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory model: acks every cycle except for an armed stall on one beat offset.
    logic [31:0] beat_addr[$];
    logic [31:0] beat_wdata[$];
    logic        beat_we[$];
    int          beat_cyc[$];
    logic [31:0] stall_addr[$];
    logic [31:0] stall_wdata[$];
    int          stall_beat = -1;
    int          stall_left = 0;
    logic        force_ack  = 1'b0;

    always @(negedge clk) begin
        if (ifc.mem_req === 1'b1) begin
            if (stall_left > 0 && int'(ifc.mem_addr[3:2]) == stall_beat) begin
                ifc.mem_ack = 1'b0;
                stall_left--;
                stall_addr.push_back(ifc.mem_addr);
                stall_wdata.push_back(ifc.mem_wdata);
            end else begin
                ifc.mem_ack   = 1'b1;
                ifc.mem_rdata = ifc.mem_addr ^ 32'h5A5A_0000;
                beat_addr.push_back(ifc.mem_addr);
                beat_wdata.push_back(ifc.mem_wdata);
                beat_we.push_back(ifc.mem_we);
                beat_cyc.push_back(cyc);
            end
        end else begin
            ifc.mem_ack   = force_ack;
            ifc.mem_rdata = 32'hDEAD_BEEF;
        end
    end

    task automatic clear_q();
        beat_addr.delete();
        beat_wdata.delete();
        beat_we.delete();
        beat_cyc.delete();
        stall_addr.delete();
        stall_wdata.delete();
    endtask

    // Returns the absolute cycle of the next done pulse, or 99999 on timeout.
    task automatic wait_done(output int dcyc, output logic which_d);
        dcyc    = 99999;
        which_d = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (ifc.i_done === 1'b1 || ifc.d_done === 1'b1) begin
                dcyc    = cyc;
                which_d = ifc.d_done;
                return;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    logic [127:0] rline_exp;
    int           s, dc;
    logic         wd;
    logic         seen;
    logic [3:0]   rr_exp;

    initial begin
        reset       = 1'b0;
        ifc.i_req   = 1'b0;
        ifc.i_addr  = '0;
        ifc.d_req   = 1'b0;
        ifc.d_we    = 1'b0;
        ifc.d_addr  = '0;
        ifc.d_wline = '0;
        repeat (3) @(negedge clk);
        chk("rst_mem_req", ifc.mem_req, 0);
        chk("rst_mem_we", ifc.mem_we, 0);
        chk("rst_mem_addr", ifc.mem_addr, 0);
        chk("rst_mem_wdata", ifc.mem_wdata, 0);
        chk("rst_i_done", ifc.i_done, 0);
        chk("rst_d_done", ifc.d_done, 0);
        chk("rst_busy", ifc.busy, 0);
        chk("rst_rline", ifc.rline, 0);
        reset = 1'b1;
        @(negedge clk);

        // Instruction line fill, zero wait states, unaligned address
        clear_q();
        s = cyc;
        ifc.i_addr = 32'h0000_1234;
        ifc.i_req  = 1'b1;
        wait_done(dc, wd);
        ifc.i_req = 1'b0;
        chk("a_done_lat", dc - s, 5);
        chk("a_owner_i", wd, 0);
        chk("a_nbeats", beat_addr.size(), 4);
        if (beat_addr.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("a_addr%0d", k), beat_addr[k], 32'h1230 + 4 * k);
                chk($sformatf("a_cyc%0d", k), beat_cyc[k] - s, k + 1);
                chk($sformatf("a_we%0d", k), beat_we[k], 0);
            end
        end
        rline_exp = {32'h5A5A_123C, 32'h5A5A_1238, 32'h5A5A_1234, 32'h5A5A_1230};
        chk("a_rline", ifc.rline, rline_exp);
        @(negedge clk);
        chk("a_done_once", ifc.i_done, 0);
        chk("a_idle", ifc.busy, 0);

        // Data write-back; inputs scrambled after grant must not leak in
        clear_q();
        s = cyc;
        ifc.d_addr  = 32'h40;
        ifc.d_we    = 1'b1;
        ifc.d_wline = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        ifc.d_req   = 1'b1;
        @(negedge clk);
        ifc.d_addr  = 32'hFFF0;
        ifc.d_wline = {4{32'h1111_1111}};
        wait_done(dc, wd);
        ifc.d_req = 1'b0;
        ifc.d_we  = 1'b0;
        chk("b_done_lat", dc - s, 5);
        chk("b_owner_d", wd, 1);
        chk("b_nbeats", beat_addr.size(), 4);
        if (beat_addr.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("b_addr%0d", k), beat_addr[k], 32'h40 + 4 * k);
                chk($sformatf("b_wdata%0d", k), beat_wdata[k], 32'hA0 + k);
                chk($sformatf("b_we%0d", k), beat_we[k], 1);
            end
        end
        chk("b_rline_kept", ifc.rline, rline_exp);
        @(negedge clk);
        chk("b_done_once", ifc.d_done, 0);

        // Write-back with a 3-cycle stall on beat 2
        clear_q();
        stall_beat = 2;
        stall_left = 3;
        s = cyc;
        ifc.d_addr  = 32'h200;
        ifc.d_we    = 1'b1;
        ifc.d_wline = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
        ifc.d_req   = 1'b1;
        wait_done(dc, wd);
        ifc.d_req = 1'b0;
        ifc.d_we  = 1'b0;
        stall_beat = -1;
        chk("c_done_lat", dc - s, 8);
        chk("c_nstall", stall_addr.size(), 3);
        for (int k = 0; k < stall_addr.size(); k++) begin
            chk($sformatf("c_stall_addr%0d", k), stall_addr[k], 32'h208);
            chk($sformatf("c_stall_wdata%0d", k), stall_wdata[k], 32'hB2);
        end
        chk("c_nbeats", beat_addr.size(), 4);
        if (beat_addr.size() == 4) begin
            chk("c_beat2_addr", beat_addr[2], 32'h208);
            chk("c_beat2_wdata", beat_wdata[2], 32'hB2);
            chk("c_beat2_cyc", beat_cyc[2] - s, 6);
            chk("c_beat3_cyc", beat_cyc[3] - s, 7);
        end
        @(negedge clk);

        // Round robin after reset: D wins first tie, then strict alternation
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        clear_q();
        rr_exp = 4'b0101;
        ifc.i_addr = 32'h1000;
        ifc.d_addr = 32'h2000;
        ifc.i_req  = 1'b1;
        ifc.d_req  = 1'b1;
        for (int t = 0; t < 4; t++) begin
            wait_done(dc, wd);
            chk($sformatf("d_rr_owner%0d", t), wd, rr_exp[t]);
            if (t == 3) begin
                ifc.i_req = 1'b0;
                ifc.d_req = 1'b0;
            end
        end
        chk("d_nbeats", beat_addr.size(), 16);
        if (beat_addr.size() == 16) begin
            chk("d_first0", beat_addr[0], 32'h2000);
            chk("d_first1", beat_addr[4], 32'h1000);
            chk("d_first2", beat_addr[8], 32'h2000);
            chk("d_first3", beat_addr[12], 32'h1000);
        end
        chk("d_rline", ifc.rline, {32'h5A5A_100C, 32'h5A5A_1008, 32'h5A5A_1004, 32'h5A5A_1000});
        @(negedge clk);
        chk("d_idle", ifc.busy, 0);

        // Reset during beat 1 abandons the burst
        clear_q();
        ifc.i_addr = 32'h300;
        ifc.i_req  = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("e_async_mem_req", ifc.mem_req, 0);
        chk("e_async_busy", ifc.busy, 0);
        chk("e_async_addr", ifc.mem_addr, 0);
        chk("e_async_rline", ifc.rline, 0);
        ifc.i_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (ifc.i_done !== 1'b0 || ifc.d_done !== 1'b0 || ifc.mem_req !== 1'b0) seen = 1'b1;
        end
        chk("e_no_done", seen, 0);
        clear_q();
        s = cyc;
        ifc.i_addr = 32'h500;
        ifc.i_req  = 1'b1;
        wait_done(dc, wd);
        ifc.i_req = 1'b0;
        chk("e_restart_lat", dc - s, 5);
        chk("e_restart_n", beat_addr.size(), 4);
        if (beat_addr.size() > 0) chk("e_restart_addr0", beat_addr[0], 32'h500);
        @(negedge clk);

        // Request dropped after beat 0, then stray acks while idle
        clear_q();
        s = cyc;
        ifc.i_addr = 32'h600;
        ifc.i_req  = 1'b1;
        @(negedge clk);
        ifc.i_req = 1'b0;
        wait_done(dc, wd);
        chk("f_done_lat", dc - s, 5);
        chk("f_owner_i", wd, 0);
        chk("f_nbeats", beat_addr.size(), 4);
        force_ack = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("f_stray_req%0d", k), ifc.mem_req, 0);
            chk($sformatf("f_stray_busy%0d", k), ifc.busy, 0);
        end
        force_ack = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter LINE_WORDS, default 4, 32-bit words per cache-line burst; supported values 2, 4, 8.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 i_req  input  1  instruction-cache line-fill request; level, held until i_done.
REQ-005 i_addr  input  32  fetch miss address; bits [log2(LINE_WORDS)+1:0] ignored.
REQ-006 d_req  input  1  data-cache line request; level, held until d_done.
REQ-007 d_we  input  1  1 = line write-back, 0 = line fill.
REQ-008 d_addr  input  32  data miss/write-back address; low line-offset bits ignored.
REQ-009 d_wline  input  32*LINE_WORDS  write-back line; word k at bits [32k+31:32k].
REQ-010 mem_req  output  1  memory beat request.
REQ-011 mem_we  output  1  beat is a write.
REQ-012 mem_addr  output  32  beat address = line base + 4*beat.
REQ-013 mem_wdata  output  32  write beat data.
REQ-014 mem_rdata  input  32  read beat data, valid with mem_ack.
REQ-015 mem_ack  input  1  beat accepted/completed this cycle.
REQ-016 i_done / d_done  output  1 each  one-cycle completion pulses.
REQ-017 rline  output  32*LINE_WORDS  assembled read line; word k at bits [32k+31:32k].
REQ-018 busy  output  1  high in any state except IDLE; the pipeline holds pc_en/dhit low while busy or while a requester is pending.

Function
REQ-019 FSM states IDLE, BURST, DONE; IDLE -> BURST on grant; BURST -> DONE on the ack of beat LINE_WORDS-1; DONE -> IDLE unconditionally after one cycle.
REQ-020 Requests are sampled in IDLE only; grant is registered: req sampled at edge E0 -> mem_req high from cycle after E0.
REQ-021 Arbitration: single requester pending -> granted; both pending -> requester not granted last wins (round-robin); last_grant resets to I, so D wins the first tie.
REQ-022 On grant, line base (address with offset bits cleared), direction (I: read; D: d_we) and, for writes, d_wline are latched; later input changes do not affect the burst.
REQ-023 Beat counter (log2(LINE_WORDS) bits) starts at 0, increments only on mem_ack in BURST; no wrap beyond LINE_WORDS-1.
REQ-024 mem_req = 1 exactly in BURST; mem_addr/mem_we/mem_wdata stable while mem_ack = 0 (wait states of any length permitted).
REQ-025 Read beat k: mem_rdata captured into rline word k on the ack edge; writes leave rline unchanged.
REQ-026 In DONE: i_done or d_done (owner only) = 1 for exactly one cycle; rline holds the full line during that cycle and until the next read burst writes it.
REQ-027 With zero wait states: req at E0 -> mem_req cycles 1..LINE_WORDS -> done in cycle LINE_WORDS+1 -> IDLE cycle LINE_WORDS+2; earliest next mem_req in cycle LINE_WORDS+3.
REQ-028 A request dropped mid-burst does not abort; the burst completes and done still pulses.
REQ-029 mem_ack outside BURST is ignored.
REQ-030 Requester re-asserting in the same cycle its done pulses is not sampled until IDLE.

Reset
REQ-031 reset = 0 forces asynchronously: state IDLE, beat 0, last_grant I, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, i_done 0, d_done 0, busy 0, rline 0.
REQ-032 Reset mid-burst abandons the transfer; no done pulse after release; first sampling in the first IDLE cycle after release.

Structure
REQ-033 Shared package holds the state enum (IDLE, BURST, DONE), requester ID enum (REQ_I, REQ_D) and the default LINE_WORDS constant.
REQ-034 One sub-module, arb_rr2, a two-requester round-robin priority picker (combinational pick plus last_grant register).

Verification
REQ-035 i_req=1, i_addr=0x0000_1234, ack every cycle, LINE_WORDS=4 -> mem_addr 0x1230,0x1234,0x1238,0x123C in cycles 1-4; i_done in cycle 5; rline = four rdata words in order.
REQ-036 i_req and d_req both set at first post-reset IDLE -> D served first, then I; repeated ties alternate D,I,D,I.
REQ-037 d_req=1, d_we=1, d_addr=0x40, d_wline word k = 0xA0+k -> four writes to 0x40..0x4C with data 0xA0..0xA3; rline unchanged; d_done pulses once.
REQ-038 Ack withheld 3 cycles on beat 2 -> mem_addr/mem_wdata stable for the wait; done delayed exactly 3 cycles.
REQ-039 reset low during beat 1 -> mem_req 0 immediately (asynchronous), no done pulse; fresh i_req after release restarts at beat 0.
REQ-040 i_req dropped after beat 0 -> burst still completes, i_done pulses; stray mem_ack in IDLE -> no state change.
